// File: rtl/bin2csd_seq.sv
// Sequential binary-to-CSD recoder: one digit per cycle, LSB first.
// Emits W+1 signed digits plus the non-zero digit count for shift-add sizing.
module bin2csd_seq #(
    parameter int W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              x,
    input  logic                      sgn,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*(W+1)-1:0]        y,
    output logic [$clog2(W+2)-1:0]    nnz
);

    localparam int NW = $clog2(W + 2);
    localparam int XW = W + 2;
    localparam int IW = $clog2(W + 2);
    localparam int YW = 2 * (W + 1);

    localparam logic [1:0] D_ZERO = 2'b00;
    localparam logic [1:0] D_POS  = 2'b01;
    localparam logic [1:0] D_NEG  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t          state, state_n;
    logic [XW-1:0]   xe, xe_n;
    logic            carry, carry_n;
    logic [IW-1:0]   idx, idx_n;
    logic [YW-1:0]   y_q, y_n;
    logic [NW-1:0]   nnz_q, nnz_n;

    logic            cur;
    logic            nxt;
    logic [1:0]      dig;
    logic            dig_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            xe    <= '0;
            carry <= 1'b0;
            idx   <= '0;
            y_q   <= '0;
            nnz_q <= '0;
        end else begin
            state <= state_n;
            xe    <= xe_n;
            carry <= carry_n;
            idx   <= idx_n;
            y_q   <= y_n;
            nnz_q <= nnz_n;
        end
    end

    // Two-bit extension leaves room for the lookahead bit of digit W.
    always_comb begin
        cur       = xe[idx];
        nxt       = xe[idx + IW'(1)];
        dig       = D_ZERO;
        dig_carry = 1'b0;
        unique case ({cur, carry})
            2'b00: begin
                dig       = D_ZERO;
                dig_carry = 1'b0;
            end
            2'b11: begin
                dig       = D_ZERO;
                dig_carry = 1'b1;
            end
            2'b01, 2'b10: begin
                if (nxt) begin
                    dig       = D_NEG;
                    dig_carry = 1'b1;
                end else begin
                    dig       = D_POS;
                    dig_carry = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        state_n = state;
        xe_n    = xe;
        carry_n = carry;
        idx_n   = idx;
        y_n     = y_q;
        nnz_n   = nnz_q;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    xe_n    = {{2{sgn & x[W-1]}}, x};
                    carry_n = 1'b0;
                    idx_n   = '0;
                    y_n     = '0;
                    nnz_n   = '0;
                    state_n = CONV;
                end
            end
            CONV: begin
                for (int k = 0; k <= W; k++) begin
                    if (idx == IW'(k)) begin
                        y_n[2*k +: 2] = dig;
                    end
                end
                carry_n = dig_carry;
                if (dig != D_ZERO) begin
                    nnz_n = nnz_q + NW'(1);
                end
                // Carry out of the top digit is dropped by design.
                if (idx == IW'(W)) begin
                    state_n = DONE;
                end else begin
                    idx_n = idx + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign y         = y_q;
    assign nnz       = nnz_q;

endmodule

// File: tb/tb_bin2csd_seq.sv
// Scoreboarded bench for bin2csd_seq: W=8 random/exhaustive, W=4 directed.
// Reference recodes with integer NAF arithmetic on the operand value.
module tb_bin2csd_seq;

    localparam int W  = 8;
    localparam int NW = $clog2(W + 2);
    localparam int YW = 2 * (W + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, in_ready, sgn, out_valid, out_ready;
    logic [W-1:0]  x;
    logic [YW-1:0] y;
    logic [NW-1:0] nnz;

    logic          rst4, iv4, ir4, sg4, ov4, or4;
    logic [3:0]    x4;
    logic [9:0]    y4;
    logic [2:0]    nnz4;

    bin2csd_seq #(.W(W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .nnz(nnz)
    );

    bin2csd_seq #(.W(4)) u_dut4 (
        .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4),
        .x(x4), .sgn(sg4), .out_valid(ov4), .out_ready(or4),
        .y(y4), .nnz(nnz4)
    );

    typedef struct {
        logic [YW-1:0] y;
        logic [NW-1:0] nnz;
        longint        val;
        bit            sgn;
    } exp8_t;

    typedef struct {
        logic [9:0] y;
        logic [2:0] nnz;
    } exp4_t;

    exp8_t q8[$];
    exp4_t q4[$];

    int tests = 0;
    int fails = 0;
    bit rnd_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Non-adjacent form by repeated halving; unique, so it is the CSD.
    function automatic logic [63:0] csd_ref(input longint v, output int cnt);
        logic [63:0] r;
        longint      m;
        r   = '0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (v % 2 != 0) begin
                m = ((v % 4) + 4) % 4;
                if (m == 1) begin
                    r[2*i +: 2] = 2'b01;
                    v = v - 1;
                end else begin
                    r[2*i +: 2] = 2'b11;
                    v = v + 1;
                end
                cnt++;
            end
            v = v / 2;
        end
        return r;
    endfunction

    task automatic push8(input logic [W-1:0] v, input logic s);
        exp8_t       e;
        logic [63:0] r;
        int          cnt;
        e.val = s ? longint'($signed(v)) : longint'(v);
        r     = csd_ref(e.val, cnt);
        e.y   = r[YW-1:0];
        e.nnz = NW'(cnt);
        e.sgn = s;
        q8.push_back(e);
    endtask

    // Monitor for the W=8 instance: exact match plus structural properties.
    longint      m_val;
    int          m_pc;
    bit          m_adj, m_bad;
    logic [1:0]  m_d, m_prev;
    exp8_t       m_e;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected8: got y=%0h with empty queue", y);
            end else begin
                m_e   = q8.pop_front();
                m_val = 0;
                m_pc  = 0;
                m_adj = 1'b0;
                m_bad = 1'b0;
                m_prev = 2'b00;
                for (int i = 0; i <= W; i++) begin
                    m_d = y[2*i +: 2];
                    if (m_d == 2'b01) m_val = m_val + (longint'(1) << i);
                    if (m_d == 2'b11) m_val = m_val - (longint'(1) << i);
                    if (m_d == 2'b10) m_bad = 1'b1;
                    if (m_d != 2'b00) m_pc++;
                    if (m_d != 2'b00 && m_prev != 2'b00) m_adj = 1'b1;
                    m_prev = m_d;
                end
                chk("y8", 64'(y), 64'(m_e.y));
                chk("nnz8", 64'(nnz), 64'(m_e.nnz));
                chk("value8", m_val, m_e.val);
                chk("adjacent8", 64'(m_adj), 64'd0);
                chk("encoding8", 64'(m_bad), 64'd0);
                chk("popcount8", 64'(nnz), 64'(m_pc));
                chk("nnzmax8", 64'(nnz <= NW'((W + 2) / 2)), 64'd1);
                if (m_e.sgn) chk("msd8", 64'(y[2*W +: 2]), 64'd0);
            end
        end
    end

    exp4_t m4;
    always @(negedge clk) begin
        if (!rst4 && ov4 && or4) begin
            if (q4.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected4: got y=%0h with empty queue", y4);
            end else begin
                m4 = q4.pop_front();
                chk("y4", 64'(y4), 64'(m4.y));
                chk("nnz4", 64'(nnz4), 64'(m4.nnz));
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic send4(input logic [3:0] v, input logic s, input bit push,
                         input logic [9:0] ey, input logic [2:0] en,
                         input bit lat);
        int    n;
        exp4_t e;
        @(posedge clk);
        #1;
        iv4 = 1'b1;
        x4  = v;
        sg4 = s;
        n   = 0;
        @(negedge clk);
        while (!ir4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ir4) begin
            fail_now("accept4");
            iv4 = 1'b0;
            return;
        end
        if (push) begin
            e.y   = ey;
            e.nnz = en;
            q4.push_back(e);
        end
        @(posedge clk);
        #1;
        iv4 = 1'b0;
        if (lat) begin
            for (int c = 1; c <= 5; c++) begin
                @(posedge clk);
                #1;
                if (c == 4) chk("lat4_early", 64'(ov4), 64'd0);
                if (c == 5) chk("lat4_valid", 64'(ov4), 64'd1);
            end
        end
    endtask

    task automatic drain4();
        int n = 0;
        while (q4.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q4.size() != 0) fail_now("drain4");
        @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high so operands go back to back.
    task automatic send8(input logic [W-1:0] v, input logic s);
        int n;
        x        = v;
        sgn      = s;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("accept8");
        end else begin
            push8(v, s);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;  in_valid = 1'b0; x = '0;  sgn = 1'b0;
        rst4 = 1'b1; iv4 = 1'b0;      x4 = '0; sg4 = 1'b0; or4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        rst4 = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_nnz", 64'(nnz), 64'd0);
        chk("rst4_in_ready", 64'(ir4), 64'd1);
        chk("rst4_y", 64'(y4), 64'd0);

        send4(4'b0111, 1'b0, 1'b1, 10'b00_01_00_00_11, 3'd2, 1'b1);
        send4(4'b1111, 1'b0, 1'b1, 10'b01_00_00_00_11, 3'd2, 1'b0);
        send4(4'b1111, 1'b1, 1'b1, 10'b00_00_00_00_11, 3'd1, 1'b0);
        send4(4'b1000, 1'b1, 1'b1, 10'b00_11_00_00_00, 3'd1, 1'b0);
        send4(4'b0110, 1'b0, 1'b1, 10'b00_01_00_11_00, 3'd2, 1'b0);
        send4(4'b0000, 1'b0, 1'b1, 10'b00_00_00_00_00, 3'd0, 1'b0);
        drain4();

        or4 = 1'b0;
        send4(4'b0111, 1'b0, 1'b1, 10'b00_01_00_00_11, 3'd2, 1'b0);
        n = 0;
        while (!ov4 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ov4) fail_now("bp_valid4");
        iv4 = 1'b1;
        x4  = 4'b0110;
        sg4 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_y4", 64'(y4), 64'(10'b00_01_00_00_11));
            chk("bp_nnz4", 64'(nnz4), 64'd2);
            chk("bp_valid4", 64'(ov4), 64'd1);
            chk("bp_in_ready4", 64'(ir4), 64'd0);
        end
        @(posedge clk);
        #1;
        or4 = 1'b1;
        send4(4'b0110, 1'b0, 1'b1, 10'b00_01_00_11_00, 3'd2, 1'b0);
        drain4();

        send4(4'b1111, 1'b0, 1'b0, 10'd0, 3'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst4 = 1'b1;
        @(posedge clk);
        #1;
        rst4 = 1'b0;
        chk("midrst_in_ready4", 64'(ir4), 64'd1);
        chk("midrst_out_valid4", 64'(ov4), 64'd0);
        chk("midrst_y4", 64'(y4), 64'd0);
        chk("midrst_nnz4", 64'(nnz4), 64'd0);
        send4(4'b1000, 1'b1, 1'b1, 10'b00_11_00_00_00, 3'd1, 1'b0);
        drain4();

        rnd_en = 1'b1;
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 256; v++) begin
                send8(W'(v), m[0]);
            end
        end
        for (int k = 0; k < 200; k++) begin
            send8(W'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
        n = 0;
        while (q8.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (q8.size() != 0) fail_now("drain8");
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
